// File: rtl/audio_mem_sequencer_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | audio_mem_sequencer_if: control, PDM and sample-memory bus         |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
interface audio_mem_sequencer_if #(
  parameter int ADDR_W = 17,
  parameter int DATA_W = 16
);
  logic              rec_start;
  logic              play_start;
  logic              abort;
  logic              rec_bank;
  logic              play_bank;
  logic              des_valid;
  logic [DATA_W-1:0] des_word;
  logic              ser_req;
  logic [DATA_W-1:0] ser_word;
  logic              ser_word_valid;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_din;
  logic              mem_we0;
  logic              mem_we1;
  logic [DATA_W-1:0] mem_dout0;
  logic [DATA_W-1:0] mem_dout1;
  logic              recording;
  logic              playing;
  logic              done;
  logic              underrun;

  modport slave (
    input  rec_start, play_start, abort, rec_bank, play_bank,
    input  des_valid, des_word, ser_req, mem_dout0, mem_dout1,
    output ser_word, ser_word_valid, mem_addr, mem_din, mem_we0, mem_we1,
    output recording, playing, done, underrun
  );

  modport master (
    output rec_start, play_start, abort, rec_bank, play_bank,
    output des_valid, des_word, ser_req, mem_dout0, mem_dout1,
    input  ser_word, ser_word_valid, mem_addr, mem_din, mem_we0, mem_we1,
    input  recording, playing, done, underrun
  );
endinterface
`default_nettype wire

// File: rtl/audio_mem_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | audio_mem_sequencer: record/playback sequencer for two sample banks |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module audio_mem_sequencer #(
  parameter int ADDR_W    = 17,
  parameter int DATA_W    = 16,
  parameter int MAX_WORDS = 125000
) (
  input  wire                  clock,
  input  wire                  reset,
  audio_mem_sequencer_if.slave bus
);
  // Counters and lengths carry one extra bit so a full bank of 2^ADDR_W words fits.
  localparam int               CNT_W       = ADDR_W + 1;
  localparam logic [CNT_W-1:0] c_max_words = CNT_W'(MAX_WORDS);
  localparam logic [CNT_W-1:0] c_last_word = CNT_W'(MAX_WORDS - 1);

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_REC        = 3'd1,
    S_PLAY_FETCH = 3'd2,
    S_PLAY_LOAD  = 3'd3,
    S_PLAY_HOLD  = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  addr_q, addr_d;
  logic [CNT_W-1:0]  len0_q, len0_d;
  logic [CNT_W-1:0]  len1_q, len1_d;
  logic              bank_q, bank_d;
  logic [DATA_W-1:0] ser_word_q, ser_word_d;
  logic              ser_word_valid_q, ser_word_valid_d;
  logic              done_q, done_d;
  logic              underrun_q, underrun_d;

  logic              w_playing;
  logic              w_wr;
  logic [CNT_W-1:0]  w_cur_len;
  logic [CNT_W-1:0]  w_play_len;

  assign w_playing  = (state_q == S_PLAY_FETCH) || (state_q == S_PLAY_LOAD) ||
                      (state_q == S_PLAY_HOLD);
  assign w_wr       = (state_q == S_REC) && bus.des_valid && !bus.abort;
  assign w_cur_len  = bank_q ? len1_q : len0_q;
  assign w_play_len = bus.play_bank ? len1_q : len0_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q          <= S_IDLE;
      addr_q           <= '0;
      len0_q           <= '0;
      len1_q           <= '0;
      bank_q           <= 1'b0;
      ser_word_q       <= '0;
      ser_word_valid_q <= 1'b0;
      done_q           <= 1'b0;
      underrun_q       <= 1'b0;
    end else begin
      state_q          <= state_d;
      addr_q           <= addr_d;
      len0_q           <= len0_d;
      len1_q           <= len1_d;
      bank_q           <= bank_d;
      ser_word_q       <= ser_word_d;
      ser_word_valid_q <= ser_word_valid_d;
      done_q           <= done_d;
      underrun_q       <= underrun_d;
    end
  end

  always_comb begin
    state_d          = state_q;
    addr_d           = addr_q;
    len0_d           = len0_q;
    len1_d           = len1_q;
    bank_d           = bank_q;
    ser_word_d       = ser_word_q;
    ser_word_valid_d = ser_word_valid_q;
    done_d           = 1'b0;
    underrun_d       = underrun_q;

    if (w_playing && bus.ser_req && !ser_word_valid_q) begin
      underrun_d = 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        addr_d = '0;
        if (bus.rec_start) begin
          bank_d     = bus.rec_bank;
          underrun_d = 1'b0;
          state_d    = S_REC;
        end else if (bus.play_start) begin
          bank_d     = bus.play_bank;
          underrun_d = 1'b0;
          if (w_play_len == '0) begin
            done_d = 1'b1;
          end else begin
            state_d = S_PLAY_FETCH;
          end
        end
      end

      S_REC: begin
        if (bus.abort) begin
          if (bank_q) len1_d = addr_q;
          else        len0_d = addr_q;
          done_d  = 1'b1;
          addr_d  = '0;
          state_d = S_IDLE;
        end else if (bus.des_valid) begin
          if (addr_q == c_last_word) begin
            if (bank_q) len1_d = c_max_words;
            else        len0_d = c_max_words;
            done_d  = 1'b1;
            addr_d  = '0;
            state_d = S_IDLE;
          end else begin
            addr_d = addr_q + 1'b1;
          end
        end
      end

      S_PLAY_FETCH: begin
        state_d = S_PLAY_LOAD;
      end

      // Memory data for the address presented in FETCH is valid now.
      S_PLAY_LOAD: begin
        ser_word_d       = bank_q ? bus.mem_dout1 : bus.mem_dout0;
        ser_word_valid_d = 1'b1;
        addr_d           = addr_q + 1'b1;
        state_d          = S_PLAY_HOLD;
      end

      S_PLAY_HOLD: begin
        if (bus.ser_req) begin
          ser_word_valid_d = 1'b0;
          if (addr_q == w_cur_len) begin
            done_d     = 1'b1;
            ser_word_d = '0;
            addr_d     = '0;
            state_d    = S_IDLE;
          end else begin
            state_d = S_PLAY_FETCH;
          end
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (w_playing && bus.abort) begin
      done_d           = 1'b1;
      ser_word_d       = '0;
      ser_word_valid_d = 1'b0;
      addr_d           = '0;
      state_d          = S_IDLE;
    end
  end

  assign bus.mem_we0        = w_wr && !bank_q;
  assign bus.mem_we1        = w_wr && bank_q;
  assign bus.mem_addr       = (state_q == S_IDLE) ? '0 : addr_q[ADDR_W-1:0];
  assign bus.mem_din        = (state_q == S_REC) ? bus.des_word : '0;
  assign bus.ser_word       = ser_word_q;
  assign bus.ser_word_valid = ser_word_valid_q;
  assign bus.recording      = (state_q == S_REC);
  assign bus.playing        = w_playing;
  assign bus.done           = done_q;
  assign bus.underrun       = underrun_q;
endmodule
`default_nettype wire

// File: tb/tb_audio_mem_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_audio_mem_sequencer: randomized record/playback against a model |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module tb_audio_mem_sequencer;
  localparam int ADDR_W    = 3;
  localparam int DATA_W    = 16;
  localparam int MAX_WORDS = 8;
  localparam int DEPTH     = 1 << ADDR_W;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  audio_mem_sequencer_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  audio_mem_sequencer #(
    .ADDR_W   (ADDR_W),
    .DATA_W   (DATA_W),
    .MAX_WORDS(MAX_WORDS)
  ) dut (
    .clock(clk),
    .reset(rst),
    .bus  (bus)
  );

  // Two synchronous banks with one cycle of read latency.
  logic [DATA_W-1:0] mem0 [DEPTH];
  logic [DATA_W-1:0] mem1 [DEPTH];
  always @(posedge clk) begin
    if (bus.mem_we0) mem0[bus.mem_addr] <= bus.mem_din;
    if (bus.mem_we1) mem1[bus.mem_addr] <= bus.mem_din;
    bus.mem_dout0 <= mem0[bus.mem_addr];
    bus.mem_dout1 <= mem1[bus.mem_addr];
  end

  // Reference model: what each bank should hold and how long it is.
  logic [DATA_W-1:0] exp_mem [2][MAX_WORDS];
  int                exp_len [2];
  bit                exp_under;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && (bus.mem_we0 || bus.mem_we1)) check_eq("we_outside_rec", bus.recording, 1);
  end

  task automatic cyc();
    @(posedge clk);
    #1;
    bus.rec_start  = 1'b0;
    bus.play_start = 1'b0;
    bus.abort      = 1'b0;
    bus.des_valid  = 1'b0;
    bus.ser_req    = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cyc();
    cyc();
    rst        = 1'b0;
    exp_len[0] = 0;
    exp_len[1] = 0;
    exp_under  = 1'b0;
  endtask

  task automatic do_record(input bit bank, input int n, input bit both_starts,
                           input bit abort_with_dv, input bit seq_words);
    int                written;
    logic [DATA_W-1:0] w;
    written = 0;
    cyc();
    bus.rec_start  = 1'b1;
    bus.rec_bank   = bank;
    bus.play_start = both_starts;
    bus.play_bank  = ~bank;
    cyc();
    @(negedge clk);
    check_eq("rec_entered", bus.recording, 1);
    check_eq("rec_not_play", bus.playing, 0);
    exp_under = 1'b0;
    check_eq("rec_under_clr", bus.underrun, 0);
    for (int i = 0; i < n; i++) begin
      int gap;
      gap = $urandom_range(0, 2);
      repeat (gap) begin
        cyc();
        @(negedge clk);
        check_eq("rec_gap_we", {bus.mem_we1, bus.mem_we0}, 0);
      end
      cyc();
      w = seq_words ? DATA_W'(i + 1) : DATA_W'($urandom);
      bus.des_valid = 1'b1;
      bus.des_word  = w;
      @(negedge clk);
      if (written < MAX_WORDS) begin
        check_eq("wr_we", {bus.mem_we1, bus.mem_we0}, bank ? 2'b10 : 2'b01);
        check_eq("wr_addr", bus.mem_addr, written);
        check_eq("wr_din", bus.mem_din, w);
        exp_mem[bank][written] = w;
        written++;
        if (written == MAX_WORDS) begin
          exp_len[bank] = MAX_WORDS;
          cyc();
          @(negedge clk);
          check_eq("full_done", bus.done, 1);
          check_eq("full_idle", bus.recording, 0);
          cyc();
          @(negedge clk);
          check_eq("full_done_once", bus.done, 0);
        end
      end else begin
        check_eq("wr_after_full", {bus.mem_we1, bus.mem_we0}, 0);
        check_eq("idle_addr", bus.mem_addr, 0);
      end
    end
    if (written < MAX_WORDS) begin
      cyc();
      bus.abort     = 1'b1;
      bus.des_valid = abort_with_dv;
      bus.des_word  = DATA_W'($urandom);
      @(negedge clk);
      check_eq("abort_no_wr", {bus.mem_we1, bus.mem_we0}, 0);
      exp_len[bank] = written;
      cyc();
      @(negedge clk);
      check_eq("rec_abort_done", bus.done, 1);
      check_eq("rec_abort_idle", bus.recording, 0);
      cyc();
      @(negedge clk);
      check_eq("rec_done_once", bus.done, 0);
    end
  endtask

  task automatic do_play(input bit bank, input int req_delay, input int abort_at, input int under_at);
    int len;
    int d;
    len = exp_len[bank];
    cyc();
    bus.play_start = 1'b1;
    bus.play_bank  = bank;
    exp_under      = 1'b0;
    if (len == 0) begin
      cyc();
      @(negedge clk);
      check_eq("empty_done", bus.done, 1);
      check_eq("empty_not_play", bus.playing, 0);
      check_eq("empty_addr", bus.mem_addr, 0);
      check_eq("empty_under", bus.underrun, 0);
      cyc();
      @(negedge clk);
      check_eq("empty_done_once", bus.done, 0);
      check_eq("empty_stay_idle", bus.playing, 0);
      return;
    end
    for (int i = 0; i < len; i++) begin
      cyc();
      @(negedge clk);
      check_eq("lat1_valid", bus.ser_word_valid, 0);
      check_eq("play_active", bus.playing, 1);
      cyc();
      if (i == under_at) begin
        bus.ser_req = 1'b1;
        exp_under   = 1'b1;
      end
      @(negedge clk);
      check_eq("lat2_valid", bus.ser_word_valid, 0);
      cyc();
      @(negedge clk);
      check_eq("lat3_valid", bus.ser_word_valid, 1);
      check_eq("ser_word", bus.ser_word, exp_mem[bank][i]);
      check_eq("underrun", bus.underrun, exp_under);
      d = (req_delay < 0) ? int'($urandom_range(0, 3)) : req_delay;
      repeat (d) begin
        cyc();
        @(negedge clk);
        check_eq("hold_valid", bus.ser_word_valid, 1);
      end
      cyc();
      if (i == abort_at) begin
        bus.abort = 1'b1;
        cyc();
        @(negedge clk);
        check_eq("play_abort_done", bus.done, 1);
        check_eq("play_abort_valid", bus.ser_word_valid, 0);
        check_eq("play_abort_word", bus.ser_word, 0);
        check_eq("play_abort_idle", bus.playing, 0);
        return;
      end
      bus.ser_req = 1'b1;
    end
    cyc();
    @(negedge clk);
    check_eq("play_end_done", bus.done, 1);
    check_eq("play_end_word", bus.ser_word, 0);
    check_eq("play_end_valid", bus.ser_word_valid, 0);
    check_eq("play_end_idle", bus.playing, 0);
    check_eq("play_end_under", bus.underrun, exp_under);
  endtask

  task automatic idle_noise();
    cyc();
    bus.abort     = $urandom_range(0, 1);
    bus.des_valid = $urandom_range(0, 1);
    bus.ser_req   = $urandom_range(0, 1);
    bus.des_word  = DATA_W'($urandom);
    @(negedge clk);
    check_eq("idle_no_we", {bus.mem_we1, bus.mem_we0}, 0);
    cyc();
    @(negedge clk);
    check_eq("idle_no_done", bus.done, 0);
    check_eq("idle_state", {bus.recording, bus.playing}, 0);
    check_eq("idle_under", bus.underrun, exp_under);
  endtask

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst            = 1'b1;
    bus.rec_start  = 1'b0;
    bus.play_start = 1'b0;
    bus.abort      = 1'b0;
    bus.rec_bank   = 1'b0;
    bus.play_bank  = 1'b0;
    bus.des_valid  = 1'b0;
    bus.des_word   = '0;
    bus.ser_req    = 1'b0;

    do_reset();
    @(negedge clk);
    check_eq("rst_word", bus.ser_word, 0);
    check_eq("rst_valid", bus.ser_word_valid, 0);
    check_eq("rst_addr", bus.mem_addr, 0);
    check_eq("rst_we", {bus.mem_we1, bus.mem_we0}, 0);
    check_eq("rst_flags", {bus.recording, bus.playing, bus.done, bus.underrun}, 0);

    do_play(1'b0, -1, -1, -1);
    do_record(1'b0, 5, 1'b0, 1'b0, 1'b1);
    do_play(1'b0, 3, -1, -1);
    do_record(1'b1, 10, 1'b0, 1'b0, 1'b0);
    do_play(1'b1, -1, -1, 2);
    idle_noise();
    do_play(1'b0, -1, 2, -1);
    do_record(1'b0, 3, 1'b1, 1'b1, 1'b0);
    do_play(1'b0, 0, -1, -1);

    for (int k = 0; k < 40; k++) begin
      case ($urandom_range(0, 2))
        0: do_record(1'($urandom_range(0, 1)), int'($urandom_range(0, 11)),
                     1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);
        1: do_play(1'($urandom_range(0, 1)), -1,
                   ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 7)) : -1,
                   ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 7)) : -1);
        default: idle_noise();
      endcase
    end

    // Reset in the middle of a recording discards both lengths.
    do_record(1'b1, 4, 1'b0, 1'b0, 1'b0);
    cyc();
    bus.rec_start = 1'b1;
    bus.rec_bank  = 1'b1;
    cyc();
    bus.des_valid = 1'b1;
    bus.des_word  = 16'h1234;
    cyc();
    do_reset();
    @(negedge clk);
    check_eq("midrst_idle", {bus.recording, bus.playing}, 0);
    do_play(1'b1, -1, -1, -1);
    do_play(1'b0, -1, -1, -1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
